// File: rtl/pc_fetch_server.sv
// PC register plus 256x16 synchronous program memory answering fetch requests
// after READ_LAT cycles, with a program-load write port.
module pc_fetch_server #(
   parameter int          READ_LAT = 2,
   parameter logic [7:0]  PC_RESET = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_ram_in,
   input  logic        en_pc_pulse,
   input  logic [1:0]  pc_ctrl,
   input  logic [7:0]  offset_addr,
   input  logic        prog_we,
   input  logic [7:0]  prog_addr,
   input  logic [15:0] prog_data,
   output logic [15:0] ins,
   output logic        en_ram_out,
   output logic [7:0]  pc_out,
   output logic        busy,
   output logic        req_drop
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        accept;
   logic [7:0]  pc_q, pc_d;
   logic [15:0] rd_q, ins_hold;
   logic [15:0] mem [256];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         IDLE, RESP: begin
            if (en_ram_in) begin
               accept  = 1'b1;
               cnt_d   = LAT_M1;
               state_d = (READ_LAT == 1) ? RESP : WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_d == 2'd0) state_d = RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pc_d = pc_q;
      if (en_pc_pulse) begin
         case (pc_ctrl)
            2'b01:   pc_d = pc_q + 8'd1;
            2'b10:   pc_d = offset_addr;
            2'b11:   pc_d = pc_q + offset_addr;
            default: pc_d = pc_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= 2'd0;
         pc_q     <= PC_RESET;
         ins_hold <= 16'h0000;
         req_drop <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pc_q     <= pc_d;
         req_drop <= (state_q == WAIT) && en_ram_in;
         if (state_q == RESP) ins_hold <= rd_q;
      end
   end

   // Read is captured on the accepting edge, so later writes or PC moves
   // cannot affect a fetch already in flight; same-edge write returns old data.
   always_ff @(posedge clk) begin
      if (accept) rd_q <= mem[pc_q];
      if (prog_we) mem[prog_addr] <= prog_data;
   end

   assign ins        = (state_q == RESP) ? rd_q : ins_hold;
   assign en_ram_out = (state_q == RESP);
   assign busy       = (state_q == WAIT);
   assign pc_out     = pc_q;

endmodule
